// File: rtl/round_scorer.sv
// round_scorer: judges wall rounds from the pixel collision stream and tracks score, lives, rounds and flash
module round_scorer #(
    parameter int SCREEN_WIDTH        = 1280,
    parameter int SCREEN_HEIGHT       = 720,
    parameter int GOAL_DEPTH          = 60,
    parameter int GOAL_DEPTH_DELTA    = 10,
    parameter int COLLISION_THRESHOLD = 64,
    parameter int MAX_LIVES           = 3,
    parameter int POINTS_PER_ROUND    = 10,
    parameter int FLASH_FRAMES        = 30
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        data_valid_in,
    input  logic        is_wall_in,
    input  logic        is_person_in,
    input  logic        is_collision_in,
    input  logic [7:0]  wall_depth_in,
    input  logic        start_in,
    output logic [1:0]  state_out,
    output logic [15:0] score_out,
    output logic [2:0]  lives_out,
    output logic [7:0]  round_out,
    output logic [19:0] frame_collisions_out,
    output logic        round_result_valid_out,
    output logic        round_pass_out,
    output logic        flash_active_out
);
    localparam int FW = $clog2(FLASH_FRAMES + 1);
    localparam logic [7:0] DEPTH_LO = 8'(GOAL_DEPTH - GOAL_DEPTH_DELTA);
    localparam logic [7:0] DEPTH_HI = 8'(GOAL_DEPTH + GOAL_DEPTH_DELTA);

    typedef enum logic [1:0] {IDLE, PLAYING, RESULT, GAME_OVER} state_t;

    state_t      state_q, state_d;
    logic [15:0] score_q, score_d;
    logic [2:0]  lives_q, lives_d;
    logic [7:0]  round_q, round_d;
    logic [19:0] frame_collisions_q, frame_collisions_d;
    logic        valid_q, valid_d;
    logic        pass_q, pass_d;
    logic [19:0] acc_q, acc_d;
    logic        hit_q, hit_d;
    logic [7:0]  prev_depth_q, prev_depth_d;
    logic [FW-1:0] flash_q, flash_d;

    logic        fe, in_window, inc, frame_hit, start_ok;
    logic [19:0] count;
    logic [16:0] score_sum;
    logic        unused_ok;

    assign unused_ok = is_wall_in ^ is_person_in;

    always_comb begin
        fe        = data_valid_in && hcount_in == 11'(SCREEN_WIDTH - 1) && vcount_in == 10'(SCREEN_HEIGHT - 1);
        in_window = wall_depth_in >= DEPTH_LO && wall_depth_in <= DEPTH_HI;
        inc       = state_q == PLAYING && data_valid_in && is_collision_in && in_window && acc_q != '1;
        count     = acc_q + {19'd0, inc};
        frame_hit = count >= 20'(COLLISION_THRESHOLD);
        start_ok  = start_in && (state_q == IDLE || state_q == GAME_OVER);
        score_sum = {1'b0, score_q} + 17'(POINTS_PER_ROUND);
        state_d            = state_q;
        score_d            = score_q;
        lives_d            = lives_q;
        round_d            = round_q;
        frame_collisions_d = frame_collisions_q;
        valid_d            = 1'b0;
        pass_d             = pass_q;
        acc_d              = fe ? '0 : count;
        hit_d              = hit_q;
        prev_depth_d       = prev_depth_q;
        flash_d            = flash_q;
        if (fe) begin
            frame_collisions_d = count;
            prev_depth_d       = wall_depth_in;
            flash_d            = flash_q != '0 ? flash_q - 1'b1 : flash_q;
            if (state_q == PLAYING) begin
                hit_d   = hit_q | frame_hit;
                state_d = wall_depth_in < prev_depth_q ? RESULT : PLAYING;
            end
        end
        if (state_q == RESULT) begin
            valid_d = 1'b1;
            pass_d  = !hit_q;
            round_d = round_q + 8'd1;
            hit_d   = 1'b0;
            score_d = !hit_q ? (score_sum[16] ? 16'hFFFF : score_sum[15:0]) : score_q;
            lives_d = hit_q && lives_q != '0 ? lives_q - 3'd1 : lives_q;
            flash_d = hit_q ? FW'(FLASH_FRAMES) : flash_d;
            state_d = lives_d == '0 ? GAME_OVER : PLAYING;
        end
        if (start_ok) begin
            state_d            = PLAYING;
            score_d            = '0;
            lives_d            = 3'(MAX_LIVES);
            round_d            = '0;
            frame_collisions_d = frame_collisions_q;
            hit_d              = 1'b0;
            acc_d              = '0;
            prev_depth_d       = '0;
            flash_d            = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q            <= IDLE;
            score_q            <= '0;
            lives_q            <= '0;
            round_q            <= '0;
            frame_collisions_q <= '0;
            valid_q            <= 1'b0;
            pass_q             <= 1'b0;
            acc_q              <= '0;
            hit_q              <= 1'b0;
            prev_depth_q       <= '0;
            flash_q            <= '0;
        end else begin
            state_q            <= state_d;
            score_q            <= score_d;
            lives_q            <= lives_d;
            round_q            <= round_d;
            frame_collisions_q <= frame_collisions_d;
            valid_q            <= valid_d;
            pass_q             <= pass_d;
            acc_q              <= acc_d;
            hit_q              <= hit_d;
            prev_depth_q       <= prev_depth_d;
            flash_q            <= flash_d;
        end
    end

    assign state_out              = state_q;
    assign score_out              = score_q;
    assign lives_out              = lives_q;
    assign round_out              = round_q;
    assign frame_collisions_out   = frame_collisions_q;
    assign round_result_valid_out = valid_q;
    assign round_pass_out         = pass_q;
    assign flash_active_out       = flash_q != '0;
endmodule

// File: tb/tb_round_scorer.sv
// tb_round_scorer: directed checks of round resolution, scoring, lives, flash and reset behaviour
module tb_round_scorer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        valid = 1'b0;
    logic        coll = 1'b0;
    logic [7:0]  depth = '0;
    logic        start = 1'b0;
    logic [1:0]  state;
    logic [15:0] score;
    logic [2:0]  lives;
    logic [7:0]  round_n;
    logic [19:0] fcoll;
    logic        rvalid, rpass, flash;
    int checks = 0;
    int errors = 0;

    round_scorer dut (
        .clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
        .data_valid_in(valid), .is_wall_in(coll), .is_person_in(coll), .is_collision_in(coll),
        .wall_depth_in(depth), .start_in(start), .state_out(state), .score_out(score),
        .lives_out(lives), .round_out(round_n), .frame_collisions_out(fcoll),
        .round_result_valid_out(rvalid), .round_pass_out(rpass), .flash_active_out(flash)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic v, input logic [10:0] h, input logic [9:0] vc,
                        input logic c, input logic [7:0] d, input logic s);
        valid = v; hcount = h; vcount = vc; coll = c; depth = d; start = s;
        @(negedge clk);
    endtask

    task automatic idle();
        tick(1'b0, 11'd0, 10'd0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic fe_tick(input logic [7:0] d);
        tick(1'b1, 11'd1279, 10'd719, 1'b0, d, 1'b0);
    endtask

    task automatic coll_frame(input int n, input logic [7:0] d);
        for (int i = 0; i < n - 1; i++) tick(1'b1, 11'(i), 10'd0, 1'b1, d, 1'b0);
        tick(1'b1, 11'd1279, 10'd719, 1'b1, d, 1'b0);
    endtask

    task automatic pass_round();
        fe_tick(8'd75);
        fe_tick(8'd0);
        idle();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_score", 32'(score), 32'd0);
        chk("reset_lives", 32'(lives), 32'd0);
        chk("reset_round", 32'(round_n), 32'd0);
        chk("reset_flags", {29'd0, rvalid, rpass, flash}, 32'd0);
        rst_n = 1'b1;
        tick(1'b0, 11'd0, 10'd0, 1'b0, 8'd0, 1'b1);
        chk("start_state", 32'(state), 32'd1);
        chk("start_lives", 32'(lives), 32'd3);

        fe_tick(8'd75);
        fe_tick(8'd0);
        chk("boundary_result_state", 32'(state), 32'd2);
        idle();
        chk("pass1_pulse", {30'd0, rvalid, rpass}, 32'd3);
        chk("pass1_state", 32'(state), 32'd1);
        idle();
        chk("pulse_one_cycle", 32'(rvalid), 32'd0);
        pass_round();
        pass_round();
        chk("three_pass_score", 32'(score), 32'd30);
        chk("three_pass_lives", 32'(lives), 32'd3);
        chk("three_pass_round", 32'(round_n), 32'd3);

        coll_frame(64, 8'd60);
        chk("fc_64", 32'(fcoll), 32'd64);
        chk("no_boundary_rising", 32'(state), 32'd1);
        fe_tick(8'd0);
        chk("fc_cleared", 32'(fcoll), 32'd0);
        idle();
        chk("fail_pulse", {30'd0, rvalid, rpass}, 32'd2);
        chk("fail_lives", 32'(lives), 32'd2);
        chk("fail_score", 32'(score), 32'd30);
        chk("fail_flash_on", 32'(flash), 32'd1);
        for (int i = 0; i < 29; i++) fe_tick(8'd0);
        chk("flash_after_29", 32'(flash), 32'd1);
        fe_tick(8'd0);
        chk("flash_after_30", 32'(flash), 32'd0);

        coll_frame(500, 8'd40);
        chk("out_of_window_40", 32'(fcoll), 32'd0);
        coll_frame(1, 8'd49);
        chk("window_49", 32'(fcoll), 32'd0);
        coll_frame(1, 8'd50);
        chk("window_50", 32'(fcoll), 32'd1);
        coll_frame(63, 8'd60);
        chk("fc_63", 32'(fcoll), 32'd63);
        coll_frame(1, 8'd70);
        chk("window_70", 32'(fcoll), 32'd1);
        coll_frame(1, 8'd71);
        chk("window_71", 32'(fcoll), 32'd0);
        fe_tick(8'd0);
        idle();
        chk("sub_threshold_pass", {30'd0, rvalid, rpass}, 32'd3);
        chk("sub_threshold_score", 32'(score), 32'd40);

        for (int r = 0; r < 2; r++) begin
            coll_frame(64, 8'd60);
            fe_tick(8'd0);
            idle();
        end
        chk("game_over_state", 32'(state), 32'd3);
        chk("game_over_lives", 32'(lives), 32'd0);
        chk("game_over_round", 32'(round_n), 32'd7);
        fe_tick(8'd75);
        fe_tick(8'd0);
        idle();
        chk("game_over_no_pulse", 32'(rvalid), 32'd0);
        chk("game_over_round_held", 32'(round_n), 32'd7);
        tick(1'b0, 11'd0, 10'd0, 1'b0, 8'd0, 1'b1);
        chk("restart_state", 32'(state), 32'd1);
        chk("restart_score", 32'(score), 32'd0);
        chk("restart_lives", 32'(lives), 32'd3);
        chk("restart_round", 32'(round_n), 32'd0);
        chk("restart_flash", 32'(flash), 32'd0);

        for (int r = 0; r < 6553; r++) pass_round();
        chk("score_fffa", 32'(score), 32'hFFFA);
        chk("round_wrap", 32'(round_n), 32'd153);
        pass_round();
        chk("score_sat", 32'(score), 32'hFFFF);
        pass_round();
        chk("score_sat_hold", 32'(score), 32'hFFFF);

        for (int i = 0; i < 40; i++) tick(1'b1, 11'(i), 10'd0, 1'b1, 8'd60, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_score", 32'(score), 32'd0);
        chk("async_rst_lives", 32'(lives), 32'd0);
        chk("async_rst_fc", 32'(fcoll), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b0, 11'd0, 10'd0, 1'b0, 8'd0, 1'b1);
        coll_frame(5, 8'd60);
        chk("post_reset_fc", 32'(fcoll), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
